fp_align_shifter: RTL

// - Pre-add exponent alignment for the GPU FP adder; the inverse of the post-add normalizer.
//   The normalizer shifts left and decrements the exponent; this block shifts right and aligns.
// - Accepts two operands (mantissa, exponent) and picks the one with the larger exponent.
// - Right-shifts the smaller operand's mantissa one bit per cycle until both exponents match.
// - Returns aligned mantissas plus guard/sticky bits over a valid/ready handshake.

---
 rtl/fp_align_pkg.sv | 10 +
 rtl/fp_align_step.sv | 18 +
 rtl/fp_align_shifter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fp_align_pkg.sv
// Shared types for the FP adder exponent-alignment block.
package fp_align_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : fp_align_pkg

// File: rtl/fp_align_step.sv
// One right-shift step of the smaller mantissa, carrying guard/sticky along.
module fp_align_step #(
    parameter int M = 8
) (
    input  logic [M-1:0] mant_i,
    input  logic         guard_i,
    input  logic         sticky_i,
    output logic [M-1:0] mant_o,
    output logic         guard_o,
    output logic         sticky_o
);

    // The old guard bit moves into sticky before the new LSB becomes guard.
    assign mant_o   = mant_i >> 1;
    assign guard_o  = mant_i[0];
    assign sticky_o = sticky_i | guard_i;

endmodule : fp_align_step

// File: rtl/fp_align_shifter.sv
// Pre-add alignment: picks the larger-exponent operand and right-shifts the other
// one bit per cycle until the exponents match, reporting guard/sticky.
module fp_align_shifter
    import fp_align_pkg::*;
#(
    parameter int M = 8,
    parameter int E = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] mant_a,
    input  logic [M-1:0] mant_b,
    input  logic [E-1:0] exp_a,
    input  logic [E-1:0] exp_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] mant_big,
    output logic [M-1:0] mant_small,
    output logic         guard,
    output logic         sticky,
    output logic [E-1:0] exp_out,
    output logic         swapped
);

    localparam int CW = $clog2(M + 2);

    state_t         state_q, state_d;
    logic [M-1:0]   big_q, big_d;
    logic [M-1:0]   small_q, small_d;
    logic           guard_q, guard_d;
    logic           sticky_q, sticky_d;
    logic [E-1:0]   exp_q, exp_d;
    logic           swap_q, swap_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           swap_in;
    logic [E-1:0]   exp_big, exp_small, diff;
    logic [CW-1:0]  cnt_init;
    logic [M-1:0]   step_mant;
    logic           step_guard, step_sticky;

    // Equal exponents keep operand a as the big one; diff is never negative after the swap.
    assign swap_in   = (exp_b > exp_a);
    assign exp_big   = swap_in ? exp_b : exp_a;
    assign exp_small = swap_in ? exp_a : exp_b;
    assign diff      = exp_big - exp_small;
    // Beyond M+1 shifts every bit is already in sticky, so the count saturates there.
    assign cnt_init  = (32'(diff) > M + 1) ? CW'(M + 1) : CW'(diff);

    fp_align_step #(.M(M)) u_step (
        .mant_i   (small_q),
        .guard_i  (guard_q),
        .sticky_i (sticky_q),
        .mant_o   (step_mant),
        .guard_o  (step_guard),
        .sticky_o (step_sticky)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        big_d    = big_q;
        small_d  = small_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        exp_d    = exp_q;
        swap_d   = swap_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    big_d    = swap_in ? mant_b : mant_a;
                    small_d  = swap_in ? mant_a : mant_b;
                    exp_d    = exp_big;
                    swap_d   = swap_in;
                    cnt_d    = cnt_init;
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    state_d  = (cnt_init != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                small_d  = step_mant;
                guard_d  = step_guard;
                sticky_d = step_sticky;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            big_q    <= '0;
            small_q  <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            swap_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            big_q    <= big_d;
            small_q  <= small_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
            swap_q   <= swap_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign mant_big   = big_q;
    assign mant_small = small_q;
    assign guard      = guard_q;
    assign sticky     = sticky_q;
    assign exp_out    = exp_q;
    assign swapped    = swap_q;

endmodule : fp_align_shifter
